// File: rtl/pc_fetch_if.sv
// Instruction-fetch bus between pc_fetch, instruction memory and the decoder.
interface pc_fetch_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc_inc;
    logic [1:0]  branch_src;
    logic [15:0] br_target;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        halted;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc_inc, halted,
        input  imem_ready, imem_data, branch_src, br_target, flag_z, flag_v, flag_n
    );

    // Memory / decoder side
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc_inc, halted,
        output imem_ready, imem_data, branch_src, br_target, flag_z, flag_v, flag_n
    );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and instruction fetch sequencer: FETCH -> ISSUE -> FETCH,
// with conditional PC-relative / register branches and a sticky HALT.
module pc_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic     clk,
    input  logic     rst,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } stateT;

    stateT       state;
    logic [15:0] pc;
    logic [15:0] instrReg;
    logic        reqReg;
    logic        validReg;
    logic        haltedReg;

    logic [15:0] pcInc;
    logic [15:0] branchOffset;
    logic [15:0] nextPc;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic        condTaken;

    assign cond         = instrReg[11:9];
    assign imm9         = instrReg[8:0];
    assign pcInc        = pc + 16'd2;
    assign branchOffset = {{6{imm9[8]}}, imm9, 1'b0};

    // Evaluate the branch condition against the current flags
    always_comb begin
        condTaken = 1'b0;
        case (cond)
            3'b000: condTaken = !bus.flag_z;
            3'b001: condTaken = bus.flag_z;
            3'b010: condTaken = !bus.flag_z && !bus.flag_n;
            3'b011: condTaken = bus.flag_n;
            3'b100: condTaken = bus.flag_z || (!bus.flag_z && !bus.flag_n);
            3'b101: condTaken = bus.flag_n || bus.flag_z;
            3'b110: condTaken = bus.flag_v;
            3'b111: condTaken = 1'b1;
            default: condTaken = 1'b0;
        endcase
    end

    // Select the next PC from the decoder branch source
    always_comb begin
        nextPc = pcInc;
        if (condTaken) begin
            if (bus.branch_src[1]) begin
                nextPc = bus.br_target & 16'hFFFE;
            end else if (bus.branch_src[0]) begin
                nextPc = pcInc + branchOffset;
            end
        end
    end

    // Sequencer state, PC, instruction register and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC & 16'hFFFE;
            instrReg  <= '0;
            haltedReg <= 1'b0;
            reqReg    <= 1'b1;
            validReg  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ready) begin
                        instrReg <= bus.imem_data;
                        state    <= ISSUE;
                        reqReg   <= 1'b0;
                        validReg <= 1'b1;
                    end
                end
                ISSUE: begin
                    validReg <= 1'b0;
                    if (instrReg[15:12] == 4'b1111) begin
                        state     <= HALT;
                        haltedReg <= 1'b1;
                    end else begin
                        pc     <= nextPc;
                        state  <= FETCH;
                        reqReg <= 1'b1;
                    end
                end
                HALT: begin
                    reqReg   <= 1'b0;
                    validReg <= 1'b0;
                end
                default: begin
                    state    <= FETCH;
                    reqReg   <= 1'b1;
                    validReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req    = reqReg;
    assign bus.imem_addr   = pc;
    assign bus.instr       = instrReg;
    assign bus.instr_valid = validReg;
    assign bus.pc_inc      = pcInc;
    assign bus.halted      = haltedReg;
endmodule

// File: tb/tb_pc_fetch.sv
// Directed vector bench for pc_fetch: sequential fetch, wait states,
// all branch conditions, wrap-around, halt and reset recovery.
module tb_pc_fetch;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(16'h0001)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [15:0] instr;
        int unsigned waitCycles;
        logic [1:0]  src;
        logic [15:0] target;
        logic        z;
        logic        v;
        logic        n;
        logic [15:0] expNext;
    } vecT;

    vecT vecs [22];

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One instruction: optional wait states, fetch, issue with decoder inputs
    task automatic runInstr(input vecT v, input logic [15:0] pcNow, input logic [15:0] prevInstr);
        chk("fetchReq", {15'd0, bus.imem_req}, 16'd1);
        chk("fetchAddr", bus.imem_addr, pcNow);
        chk("fetchValid", {15'd0, bus.instr_valid}, 16'd0);
        for (int unsigned w = 0; w < v.waitCycles; w++) begin
            bus.imem_ready = 1'b0;
            bus.imem_data  = 16'hF0F0;
            tick();
            chk("waitAddr", bus.imem_addr, pcNow);
            chk("waitReq", {15'd0, bus.imem_req}, 16'd1);
            chk("waitValid", {15'd0, bus.instr_valid}, 16'd0);
            chk("waitInstr", bus.instr, prevInstr);
        end
        bus.imem_ready = 1'b1;
        bus.imem_data  = v.instr;
        tick();
        chk("issueValid", {15'd0, bus.instr_valid}, 16'd1);
        chk("issueReq", {15'd0, bus.imem_req}, 16'd0);
        chk("issueInstr", bus.instr, v.instr);
        chk("issuePcInc", bus.pc_inc, pcNow + 16'd2);
        chk("issueHalted", {15'd0, bus.halted}, 16'd0);
        // Ready with an HLT word during ISSUE must be ignored
        bus.imem_ready = 1'b1;
        bus.imem_data  = 16'hFFFF;
        bus.branch_src = v.src;
        bus.br_target  = v.target;
        bus.flag_z     = v.z;
        bus.flag_v     = v.v;
        bus.flag_n     = v.n;
        tick();
        chk("nextAddr", bus.imem_addr, v.expNext);
        chk("nextInstr", bus.instr, v.instr);
        bus.imem_ready = 1'b0;
        bus.branch_src = 2'b00;
    endtask

    initial begin
        logic [15:0] pcNow;
        logic [15:0] prevInstr;
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_data  = 16'h0000;
        bus.branch_src = 2'b00;
        bus.br_target  = 16'h0000;
        bus.flag_z = 1'b0;
        bus.flag_v = 1'b0;
        bus.flag_n = 1'b0;

        //             instr     wait src    target    z     v     n     next
        vecs[0]  = '{16'h1000, 0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002};
        vecs[1]  = '{16'h1001, 0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0004};
        vecs[2]  = '{16'h1002, 3, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0006};
        vecs[3]  = '{16'hCE00, 0, 2'b10, 16'h0011, 1'b0, 1'b0, 1'b0, 16'h0010};
        vecs[4]  = '{16'h03FE, 0, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h000E};
        vecs[5]  = '{16'h1000, 0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0010};
        vecs[6]  = '{16'h03FE, 0, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0012};
        vecs[7]  = '{16'hCE00, 0, 2'b11, 16'h1235, 1'b0, 1'b0, 1'b0, 16'h1234};
        vecs[8]  = '{16'hC000, 0, 2'b10, 16'h5555, 1'b1, 1'b0, 1'b0, 16'h1236};
        vecs[9]  = '{16'h0402, 0, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h123C};
        vecs[10] = '{16'h0602, 1, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1242};
        vecs[11] = '{16'h0802, 0, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1244};
        vecs[12] = '{16'h0A02, 0, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h124A};
        vecs[13] = '{16'h0C02, 0, 2'b01, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h124C};
        vecs[14] = '{16'h0C02, 0, 2'b01, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h1252};
        vecs[15] = '{16'h0002, 0, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1258};
        vecs[16] = '{16'hCE00, 0, 2'b10, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'hFFFE};
        vecs[17] = '{16'h1000, 0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[18] = '{16'hCE00, 0, 2'b10, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'hFFFE};
        vecs[19] = '{16'h0E01, 0, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0002};
        vecs[20] = '{16'h0F00, 0, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFE04};
        vecs[21] = '{16'hCE00, 0, 2'b10, 16'h0021, 1'b0, 1'b0, 1'b0, 16'h0020};

        tick();
        tick();
        rst = 1'b0;
        // RESET_PC=0x0001 has bit 0 dropped
        chk("rstReq", {15'd0, bus.imem_req}, 16'd1);
        chk("rstAddr", bus.imem_addr, 16'h0000);
        chk("rstValid", {15'd0, bus.instr_valid}, 16'd0);
        chk("rstHalted", {15'd0, bus.halted}, 16'd0);
        chk("rstInstr", bus.instr, 16'h0000);

        pcNow = 16'h0000;
        prevInstr = 16'h0000;
        for (int i = 0; i < 22; i++) begin
            runInstr(vecs[i], pcNow, prevInstr);
            pcNow = vecs[i].expNext;
            prevInstr = vecs[i].instr;
        end

        // HLT at 0x0020; branch inputs in ISSUE must not move the PC
        chk("hltAddr", bus.imem_addr, 16'h0020);
        bus.imem_ready = 1'b1;
        bus.imem_data  = 16'hF000;
        tick();
        chk("hltIssueValid", {15'd0, bus.instr_valid}, 16'd1);
        bus.branch_src = 2'b11;
        bus.br_target  = 16'h4444;
        bus.flag_z = 1'b1;
        bus.imem_data = 16'h1000;
        tick();
        chk("hltHalted", {15'd0, bus.halted}, 16'd1);
        for (int i = 0; i < 12; i++) begin
            bus.imem_ready = 1'b1;
            bus.imem_data  = 16'h1000 + 16'(i);
            tick();
            chk("haltReq", {15'd0, bus.imem_req}, 16'd0);
            chk("haltValid", {15'd0, bus.instr_valid}, 16'd0);
            chk("haltSticky", {15'd0, bus.halted}, 16'd1);
            chk("haltAddr", bus.imem_addr, 16'h0020);
            chk("haltInstr", bus.instr, 16'hF000);
        end
        bus.branch_src = 2'b00;
        bus.flag_z = 1'b0;

        // Reset out of HALT
        rst = 1'b1;
        bus.imem_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk("rstHaltHalted", {15'd0, bus.halted}, 16'd0);
        chk("rstHaltAddr", bus.imem_addr, 16'h0000);
        chk("rstHaltReq", {15'd0, bus.imem_req}, 16'd1);
        chk("rstHaltInstr", bus.instr, 16'h0000);

        // Move to 0x0002, then reset mid-wait while memory answers
        runInstr(vecs[0], 16'h0000, 16'h0000);
        bus.imem_ready = 1'b0;
        tick();
        chk("midWaitAddr", bus.imem_addr, 16'h0002);
        rst = 1'b1;
        bus.imem_ready = 1'b1;
        bus.imem_data  = 16'h1111;
        tick();
        rst = 1'b0;
        bus.imem_ready = 1'b0;
        chk("midRstAddr", bus.imem_addr, 16'h0000);
        chk("midRstValid", {15'd0, bus.instr_valid}, 16'd0);
        chk("midRstInstr", bus.instr, 16'h0000);
        tick();
        chk("midRstStaleValid", {15'd0, bus.instr_valid}, 16'd0);
        chk("midRstStaleReq", {15'd0, bus.imem_req}, 16'd1);
        runInstr(vecs[0], 16'h0000, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, with clock and reset ports named clk and rst.
REQ-002 The block SHALL provide parameter RESET_PC, default 16'h0000: the PC value loaded on reset; bit 0 is ignored and treated as 0.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  16  byte address of the requested instruction; equals the PC.
REQ-007 imem_ready  input  1  imem_data is valid this cycle; ignored when imem_req=0.
REQ-008 imem_data  input  16  instruction word returned by memory.
REQ-009 instr  output  16  registered instruction presented to the decoder.
REQ-010 instr_valid  output  1  one-cycle strobe: instr is being executed this cycle.
REQ-011 pc_inc  output  16  PC+2 of the instruction in instr; the PCS write data.
REQ-012 branch_src  input  2  decoder branch select: 00 next, 01 PC-relative immediate, 1x register target.
REQ-013 br_target  input  16  register data for BR.
REQ-014 flag_z, flag_v, flag_n  input  1 each  current condition flags.
REQ-015 halted  output  1  sticky; asserted once HLT has executed.

Function
REQ-016 The FSM SHALL have three states: FETCH, ISSUE and HALT.
REQ-017 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC.
REQ-018 In FETCH, when imem_ready=1, imem_data SHALL be latched into instr and the FSM SHALL move to ISSUE on the next edge; otherwise it SHALL stay in FETCH with address held.
REQ-019 In ISSUE, instr_valid SHALL be 1 and imem_req SHALL be 0; the FSM SHALL leave ISSUE after exactly one cycle.
REQ-020 In ISSUE, branch_src, br_target and the flags SHALL be sampled.
REQ-021 Condition bits are cond=instr[11:9], and imm9=instr[8:0].
REQ-022 Condition taken SHALL be: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-023 Next PC for branch_src=00, or a not-taken branch, SHALL be pc_inc.
REQ-024 Next PC for branch_src=01 taken SHALL be pc_inc + (sign_extend(imm9) << 1), in 16-bit modulo arithmetic.
REQ-025 Next PC for branch_src=1x taken SHALL be {br_target[15:1],1'b0}.
REQ-026 All PC arithmetic SHALL wrap modulo 2^16; PC 16'hFFFE SHALL increment to 16'h0000.
REQ-027 When instr[15:12]=4'b1111 in ISSUE, the PC SHALL NOT be updated, the FSM SHALL go to HALT, and halted SHALL be set on the same edge.
REQ-028 HALT SHALL be absorbing until rst: imem_req=0, instr_valid=0, halted=1, and instr and PC are held.
REQ-029 Every other opcode SHALL return the FSM from ISSUE to FETCH with the PC updated on the same edge.
REQ-030 Minimum throughput SHALL be one instruction per 2 cycles, with imem_ready asserted in the first FETCH cycle.
REQ-031 imem_ready asserted outside FETCH SHALL have no effect.
REQ-032 pc_inc SHALL be combinational PC+2 and stable throughout ISSUE.

Reset
REQ-033 While rst=1 at an edge, the block SHALL set PC=RESET_PC, instr=16'h0000, halted=0 and state=FETCH, regardless of current state, including mid-FETCH wait and HALT.
REQ-034 An outstanding memory response SHALL be discarded when reset occurs.
REQ-035 During the cycle after reset, outputs SHALL be: imem_req=1, imem_addr=RESET_PC, instr_valid=0, halted=0.

Verification
REQ-036 Sequential fetch: memory always ready, instructions ADD at 0x0000 and 0x0002 -> imem_addr 0x0000 then 0x0002, and an instr_valid pulse every 2nd cycle with pc_inc 0x0002 then 0x0004.
REQ-037 Wait states: imem_ready held low 3 cycles at 0x0004 -> imem_addr stays 0x0004, instr_valid=0 and instr unchanged until ready, then ISSUE follows.
REQ-038 Branches: PC=0x0010, B cond=001 imm9=9'h1FE (-2), Z=1 -> next fetch 0x000E; same with Z=0 -> 0x0012; BR cond=111, br_target=0x1235 -> 0x1234.
REQ-039 Wrap: PC=0xFFFE, non-branch -> next PC 0x0000; B at 0xFFFE with imm9=9'h001, cond=111 -> next PC 0x0002.
REQ-040 Halt: HLT (0xF000) at 0x0020 -> halted=1 from the next cycle, imem_req=0 for 10+ cycles, PC held at 0x0020.
REQ-041 Reset: rst from HALT, or mid-wait with imem_ready asserted in the same cycle -> halted=0, imem_addr=RESET_PC, no instr_valid from the stale data.
